// File: rtl/gpio_pad_controller_if.sv
// Bundle between the pin priority sorter / state machines and the GPIO pad controller.
// The master drives writes, pad levels and event clears; the slave returns pad drive, enables, reads and flags.
interface gpio_pad_controller_if;
  logic [31:0] in_pinsWriteData;
  logic [31:0] in_pinsWriteMask;
  logic [31:0] in_pinDirsWriteData;
  logic [31:0] in_pinDirsWriteMask;
  logic [31:0] in_padIn;
  logic [31:0] in_eventClear;
  logic [31:0] out_padOut;
  logic [31:0] out_padOe;
  logic [31:0] out_pinsRead;
  logic [31:0] out_riseEvents;
  logic [31:0] out_fallEvents;

  modport master (
    output in_pinsWriteData, in_pinsWriteMask, in_pinDirsWriteData, in_pinDirsWriteMask,
    output in_padIn, in_eventClear,
    input  out_padOut, out_padOe, out_pinsRead, out_riseEvents, out_fallEvents
  );

  modport slave (
    input  in_pinsWriteData, in_pinsWriteMask, in_pinDirsWriteData, in_pinDirsWriteMask,
    input  in_padIn, in_eventClear,
    output out_padOut, out_padOe, out_pinsRead, out_riseEvents, out_fallEvents
  );
endinterface

// File: rtl/gpio_pad_controller.sv
// GPIO pad controller: masked pad drive/direction registers, input pipeline and sticky edge flags.
// Define GPIO_INPUT_SYNC_EN for a two-flop input synchronizer (depth 2); otherwise a single input register.
module gpio_pad_controller (
  input  logic                  clk,
  input  logic                  reset,
  gpio_pad_controller_if.slave  bus
);

`ifdef GPIO_INPUT_SYNC_EN
  localparam logic [1:0] FillDone = 2'd3;
`else
  localparam logic [1:0] FillDone = 2'd2;
`endif

  logic [31:0] padOut_r;
  logic [31:0] padOe_r;
  logic [31:0] pinsRead_r;
  logic [31:0] prevPins_r;
  logic [31:0] riseEvents_r;
  logic [31:0] fallEvents_r;
  logic [1:0]  fillCount_r;

  logic [31:0] stageIn_s;
  logic [31:0] nextPadOut_s;
  logic [31:0] nextPadOe_s;
  logic [31:0] riseSet_s;
  logic [31:0] fallSet_s;
  logic [31:0] nextRise_s;
  logic [31:0] nextFall_s;
  logic [1:0]  nextFill_s;

  function automatic logic [31:0] maskedMerge(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [31:0] mask);
    return (cur & ~mask) | (data & mask);
  endfunction

`ifdef GPIO_INPUT_SYNC_EN
  logic [31:0] syncMeta_r;

  // First synchronizer flop; may go metastable, so nothing but the next stage reads it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncMeta_r <= 32'h0;
    end else begin
      syncMeta_r <= bus.in_padIn;
    end
  end

  assign stageIn_s = syncMeta_r;
`else
  assign stageIn_s = bus.in_padIn;
`endif

  // Merge masked writes, arm edge detection after the fill period, apply set-wins flag update
  always_comb begin
    nextPadOut_s = maskedMerge(padOut_r, bus.in_pinsWriteData, bus.in_pinsWriteMask);
    nextPadOe_s  = maskedMerge(padOe_r, bus.in_pinDirsWriteData, bus.in_pinDirsWriteMask);
    riseSet_s    = 32'h0;
    fallSet_s    = 32'h0;
    nextFill_s   = fillCount_r;
    if (fillCount_r == FillDone) begin
      riseSet_s = pinsRead_r & ~prevPins_r;
      fallSet_s = ~pinsRead_r & prevPins_r;
    end else begin
      nextFill_s = fillCount_r + 2'd1;
    end
    nextRise_s = (riseEvents_r & ~bus.in_eventClear) | riseSet_s;
    nextFall_s = (fallEvents_r & ~bus.in_eventClear) | fallSet_s;
  end

  // Pad drive/enable registers, last input stage, edge history, flags and fill counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      padOut_r     <= 32'h0;
      padOe_r      <= 32'h0;
      pinsRead_r   <= 32'h0;
      prevPins_r   <= 32'h0;
      riseEvents_r <= 32'h0;
      fallEvents_r <= 32'h0;
      fillCount_r  <= 2'd0;
    end else begin
      padOut_r     <= nextPadOut_s;
      padOe_r      <= nextPadOe_s;
      pinsRead_r   <= stageIn_s;
      prevPins_r   <= pinsRead_r;
      riseEvents_r <= nextRise_s;
      fallEvents_r <= nextFall_s;
      fillCount_r  <= nextFill_s;
    end
  end

  assign bus.out_padOut     = padOut_r;
  assign bus.out_padOe      = padOe_r;
  assign bus.out_pinsRead   = pinsRead_r;
  assign bus.out_riseEvents = riseEvents_r;
  assign bus.out_fallEvents = fallEvents_r;

endmodule

// File: tb/tb_gpio_pad_controller.sv
// Self-checking bench for gpio_pad_controller: sample-history reference model plus directed literal checks.
// Build with or without GPIO_INPUT_SYNC_EN; the bench picks up the matching input depth.
module tb_gpio_pad_controller;

`ifdef GPIO_INPUT_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  gpio_pad_controller_if bus ();

  gpio_pad_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: pad level sampled at each clock edge since reset, plus expected registers
  logic [31:0] samp [0:8191];
  int          mEdge   = 0;
  logic [31:0] mPadOut = 32'h0;
  logic [31:0] mPadOe  = 32'h0;
  logic [31:0] mRise   = 32'h0;
  logic [31:0] mFall   = 32'h0;

  function automatic logic [31:0] level(input int k);
    if (k < 1) return 32'h0;
    return samp[k];
  endfunction

  function automatic logic [31:0] applyWrite(input logic [31:0] cur, input logic [31:0] data,
                                             input logic [31:0] en);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 32; b++) begin
      if (en[b]) r[b] = data[b];
    end
    return r;
  endfunction

  // Edge n sees pad levels delayed by D edges; detection is ignored until D+1 edges have passed
  function automatic logic [31:0] risesAt(input int n);
    if (n < D + 2) return 32'h0;
    return level(n - D) & ~level(n - D - 1);
  endfunction

  function automatic logic [31:0] fallsAt(input int n);
    if (n < D + 2) return 32'h0;
    return ~level(n - D) & level(n - D - 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mEdge   <= 0;
      mPadOut <= 32'h0;
      mPadOe  <= 32'h0;
      mRise   <= 32'h0;
      mFall   <= 32'h0;
    end else begin
      mPadOut         <= applyWrite(mPadOut, bus.in_pinsWriteData, bus.in_pinsWriteMask);
      mPadOe          <= applyWrite(mPadOe, bus.in_pinDirsWriteData, bus.in_pinDirsWriteMask);
      mRise           <= (mRise & ~bus.in_eventClear) | risesAt(mEdge + 1);
      mFall           <= (mFall & ~bus.in_eventClear) | fallsAt(mEdge + 1);
      samp[mEdge + 1] <= bus.in_padIn;
      mEdge           <= mEdge + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model padOut",   bus.out_padOut,     mPadOut);
    check("model padOe",    bus.out_padOe,      mPadOe);
    check("model pinsRead", bus.out_pinsRead,   level(mEdge - D + 1));
    check("model rise",     bus.out_riseEvents, mRise);
    check("model fall",     bus.out_fallEvents, mFall);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] TAB_DATA   [6] = '{32'h12345678, 32'hDEADBEEF, 32'h00000000, 32'hCAFEF00D, 32'h0F0F0F0F, 32'h00000000};
  localparam logic [31:0] TAB_MASK   [6] = '{32'h0000FFFF, 32'hFF00FF00, 32'hFFFFFFFF, 32'h00000000, 32'hF0000000, 32'h00000000};
  localparam logic [31:0] TAB_DDATA  [6] = '{32'hFFFF0000, 32'h00000000, 32'h5A5A5A5A, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
  localparam logic [31:0] TAB_DMASK  [6] = '{32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFFFFF, 32'h00000000, 32'h00FF0000, 32'h00000000};
  localparam logic [31:0] TAB_PAD    [6] = '{32'h0000FF00, 32'h00FF00F0, 32'h00FF00F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0F0F0F0F};
  localparam logic [31:0] TAB_CLEAR  [6] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 32'h00000000};

  initial begin
    bus.in_pinsWriteData    = 32'h0;
    bus.in_pinsWriteMask    = 32'h0;
    bus.in_pinDirsWriteData = 32'h0;
    bus.in_pinDirsWriteMask = 32'h0;
    bus.in_eventClear       = 32'h0;
    bus.in_padIn            = 32'hFFFFFFFF;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Pads high through reset release: reads follow after D edges, no rising events
    for (int k = 1; k <= D; k++) begin
      step();
      check("pinsRead fill", bus.out_pinsRead, (k == D) ? 32'hFFFFFFFF : 32'h0);
    end
    repeat (5) step();
    check("no rise at reset", bus.out_riseEvents, 32'h0);
    check("no fall at reset", bus.out_fallEvents, 32'h0);

    bus.in_pinsWriteData = 32'hA5A5A5A5;
    bus.in_pinsWriteMask = 32'hFFFF0000;
    step();
    check("padOut masked write", bus.out_padOut, 32'hA5A50000);
    bus.in_pinsWriteData = 32'hFFFFFFFF;
    bus.in_pinsWriteMask = 32'h0;
    repeat (10) step();
    check("padOut hold", bus.out_padOut, 32'hA5A50000);

    bus.in_pinDirsWriteData = 32'h0000000F;
    bus.in_pinDirsWriteMask = 32'h000000FF;
    step();
    check("padOe write", bus.out_padOe, 32'h0000000F);
    // Only bit 0 enabled: the other enables keep their value
    bus.in_pinDirsWriteData = 32'h00000001;
    bus.in_pinDirsWriteMask = 32'h00000001;
    step();
    check("padOe bit0 only", bus.out_padOe, 32'h0000000F);
    bus.in_pinDirsWriteMask = 32'h000000FF;
    step();
    check("padOe low byte", bus.out_padOe, 32'h00000001);

    bus.in_pinDirsWriteMask = 32'h0;
    bus.in_pinsWriteData    = 32'h00000100;
    bus.in_pinsWriteMask    = 32'h00000100;
    step();
    bus.in_pinsWriteMask = 32'h0;
    check("data stored while input", bus.out_padOut, 32'hA5A50100);
    bus.in_pinDirsWriteData = 32'h00000100;
    bus.in_pinDirsWriteMask = 32'h00000100;
    step();
    bus.in_pinDirsWriteMask = 32'h0;
    check("pin enabled later", bus.out_padOe, 32'h00000101);
    check("stored data kept", bus.out_padOut, 32'hA5A50100);

    bus.in_padIn = 32'h0;
    repeat (D + 2) step();
    check("all fall", bus.out_fallEvents, 32'hFFFFFFFF);
    check("no rise on fall", bus.out_riseEvents, 32'h0);
    bus.in_eventClear = 32'hFFFFFFFF;
    step();
    bus.in_eventClear = 32'h0;
    check("fall cleared", bus.out_fallEvents, 32'h0);

    bus.in_padIn = 32'h00000008;
    for (int k = 1; k <= D + 1; k++) begin
      step();
      check("rise3 latency", bus.out_riseEvents, (k == D + 1) ? 32'h00000008 : 32'h0);
    end
    bus.in_eventClear = 32'h00000008;
    step();
    bus.in_eventClear = 32'h0;
    check("rise3 cleared", bus.out_riseEvents, 32'h0);

    // Clear on bit 5 lands on the very edge that detects its rise
    bus.in_padIn = 32'h00000028;
    for (int k = 1; k <= D; k++) step();
    bus.in_eventClear = 32'h00000020;
    step();
    bus.in_eventClear = 32'h0;
    check("set wins", bus.out_riseEvents, 32'h00000020);
    step();
    check("set wins held", bus.out_riseEvents, 32'h00000020);

    for (int r = 0; r < 6; r++) begin
      bus.in_pinsWriteData    = TAB_DATA[r];
      bus.in_pinsWriteMask    = TAB_MASK[r];
      bus.in_pinDirsWriteData = TAB_DDATA[r];
      bus.in_pinDirsWriteMask = TAB_DMASK[r];
      bus.in_padIn            = TAB_PAD[r];
      bus.in_eventClear       = TAB_CLEAR[r];
      step();
    end
    bus.in_pinsWriteMask    = 32'h0;
    bus.in_eventClear       = 32'h0;
    bus.in_pinDirsWriteData = 32'hFFFFFFFF;
    bus.in_pinDirsWriteMask = 32'hFFFFFFFF;
    bus.in_padIn            = 32'hF0F0F0F0;
    repeat (D + 3) step();
    bus.in_pinDirsWriteMask = 32'h0;
    check("all outputs", bus.out_padOe, 32'hFFFFFFFF);

    // Asynchronous reset between clock edges
    #1 reset = 1'b0;
    #1;
    check("async padOe", bus.out_padOe, 32'h0);
    check("async padOut", bus.out_padOut, 32'h0);
    check("async pinsRead", bus.out_pinsRead, 32'h0);
    check("async rise", bus.out_riseEvents, 32'h0);
    check("async fall", bus.out_fallEvents, 32'h0);
    bus.in_padIn = 32'hFFFFFFFF;
    repeat (2) step();
    reset = 1'b1;
    repeat (D + 4) step();
    check("rearm no rise", bus.out_riseEvents, 32'h0);
    check("rearm inputs", bus.out_padOe, 32'h0);
    check("rearm pinsRead", bus.out_pinsRead, 32'hFFFFFFFF);
    bus.in_padIn = 32'h0;
    repeat (D + 2) step();
    check("rearm fall", bus.out_fallEvents, 32'hFFFFFFFF);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
